// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe: NUM_IN-way operand select into a single registered valid/ready stage
//   Ports: clk, rst_n (async, active-low); in_data (NUM_IN packed WIDTH-bit sources),
//   sel, in_valid, in_ready (= !out_valid || out_ready), flush (drops held and incoming word);
//   out_data, out_valid, out_ready; sel_err (sticky illegal-select flag);
//   err_count (8-bit saturating illegal-select count, only when FWD_MUX_ERRCNT_EN is defined).
module fwd_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef FWD_MUX_ERRCNT_EN
  ,output logic [7:0]             err_count
`endif
);
  localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];
  logic [WIDTH-1:0] out_data_q, out_data_d, sel_word;
  logic out_valid_q, out_valid_d, sel_err_q, sel_err_d, accept, legal;
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == k[SEL_W-1:0]) sel_word = in_data[k*WIDTH +: WIDTH];
  end
  // An illegal index matches no source, so sel_word is already zero for it.
  assign legal    = {1'b0, sel} < NUM_IN_L;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  always_comb begin
    out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d  = accept ? sel_word : out_data_q;
    sel_err_d   = sel_err_q || (accept && !legal);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
`ifdef FWD_MUX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  always_comb err_count_d = (accept && !legal && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count_q <= '0;
    else err_count_q <= err_count_d;
  assign err_count = err_count_q;
`endif
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
endmodule
